// File: rtl/mem_block_port_pkg.sv
// rtl/mem_block_port_pkg.sv - shared block/word widths and FSM state encoding for the block memory port
package data_def;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } mem_state_t;
endpackage

// File: rtl/mem_block_port_if.sv
// rtl/mem_block_port_if.sv - cache-side block request/response bundle for mem_block_port
interface mem_block_port_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              req_i;
  logic              wr_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] rdata_o;
  logic              rdy_o;
  logic [31:0]       rd_cnt_o;
  logic [31:0]       wr_cnt_o;

  modport master (
    output req_i, wr_i, addr_i, wdata_i,
    input  rdata_o, rdy_o, rd_cnt_o, wr_cnt_o
  );

  modport slave (
    input  req_i, wr_i, addr_i, wdata_i,
    output rdata_o, rdy_o, rd_cnt_o, wr_cnt_o
  );
endinterface

// File: rtl/mem_block_port_array.sv
// rtl/mem_block_port_array.sv - DEPTH x DATA_W block storage, synchronous write and registered read
module mem_block_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 128,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Storage contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/mem_block_port.sv
// rtl/mem_block_port.sv - fixed-latency whole-block read/write-back memory stage behind the cache
// Optional build macro MEM_STATS_EN adds completed read/write counters.
module mem_block_port
  import data_def::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = BLOCK_W,
  parameter int DEPTH  = 1024,
  parameter int LAT    = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_block_port_if.slave  bus
);
  localparam int         IDX_W  = $clog2(DEPTH);
  localparam logic [7:0] LAT_M1 = 8'(LAT - 1);

  mem_state_t        state;
  logic [7:0]        cnt;
  logic              op_wr;
  logic [IDX_W-1:0]  op_idx;
  logic [DATA_W-1:0] op_wdata;
  logic              rdy_q;
  logic              fire;
  logic              unused_addr_hi;

  // Bits above the index alias onto the same block.
  assign unused_addr_hi = ^bus.addr_i[ADDR_W-1:IDX_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_wr    <= 1'b0;
      op_idx   <= '0;
      op_wdata <= '0;
      rdy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rdy_q <= 1'b0;
          if (bus.req_i) begin
            op_wr    <= bus.wr_i;
            op_idx   <= bus.addr_i[IDX_W-1:0];
            op_wdata <= bus.wdata_i;
            cnt      <= LAT_M1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            state <= RESP;
            rdy_q <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          rdy_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          rdy_q <= 1'b0;
        end
      endcase
    end
  end

  // The array access happens on the edge that enters RESP; reset on that edge drops it.
  assign fire = (state == BUSY) && (cnt == 8'd0) && !rst;

  mem_block_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (fire && op_wr),
    .waddr (op_idx),
    .wdata (op_wdata),
    .re    (fire && !op_wr),
    .raddr (op_idx),
    .rdata (bus.rdata_o)
  );

  assign bus.rdy_o = rdy_q;

`ifdef MEM_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (fire) begin
      if (op_wr) begin
        wr_cnt <= wr_cnt + 32'd1;
      end else begin
        rd_cnt <= rd_cnt + 32'd1;
      end
    end
  end

  assign bus.rd_cnt_o = rd_cnt;
  assign bus.wr_cnt_o = wr_cnt;
`else
  assign bus.rd_cnt_o = 32'd0;
  assign bus.wr_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_mem_block_port.sv
// tb/tb_mem_block_port.sv - scoreboard bench for mem_block_port with directed block ops
module tb_mem_block_port;
  localparam int LAT = 4;

  typedef struct {
    logic         is_rd;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  localparam logic [127:0] D1 = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_0000_0003;
  localparam logic [127:0] D2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D3 = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
  localparam logic [127:0] DA = 128'h0000_0001_0000_0002_0000_0003_0000_0004;
  localparam logic [127:0] DB = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
  localparam logic [127:0] DC = 128'hC0DE_C0DE_0000_FFFF_1234_5678_9ABC_DEF0;
  localparam logic [127:0] DJ = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

  mem_block_port_if #(.ADDR_W(28), .DATA_W(128)) bus ();

  mem_block_port #(
    .ADDR_W (28),
    .DATA_W (128),
    .DEPTH  (1024),
    .LAT    (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every rdy pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.rdy_o === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rdy: rdy_o=1 at cycle %0d expected no pulse", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rdy_cycle", 128'(cyc), 128'(e.cyc));
        if (e.is_rd) check("rdata", bus.rdata_o, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [27:0] a, input logic [127:0] d,
                       input logic [127:0] exp, input bit push);
    exp_t e;
    bus.req_i   = 1'b1;
    bus.wr_i    = w;
    bus.addr_i  = a;
    bus.wdata_i = d;
    if (push) begin
      e.is_rd = !w;
      e.data  = exp;
      e.cyc   = cyc + LAT + 1;
      q.push_back(e);
    end
  endtask

  task automatic run_op(input logic w, input logic [27:0] a, input logic [127:0] d,
                        input logic [127:0] exp);
    issue(w, a, d, exp, 1'b1);
    step();
    bus.req_i = 1'b0;
    repeat (LAT + 1) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_i   = 1'b0;
    bus.wr_i    = 1'b0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    repeat (2) step();
    rst = 1'b0;
    check("reset_rdy", 128'(bus.rdy_o), 128'(0));
    check("reset_rdata", bus.rdata_o, 128'(0));
    check("reset_rd_cnt", 128'(bus.rd_cnt_o), 128'(0));
    check("reset_wr_cnt", 128'(bus.wr_cnt_o), 128'(0));
    repeat (3) step();

    // Write in cycle 5 (rdy in cycle 10), then read it back.
    run_op(1'b1, 28'h10, D1, '0);
    run_op(1'b0, 28'h10, '0, D1);

    // WB->MB hand-over: req stays high, wr falls in the IDLE cycle after rdy.
    issue(1'b1, 28'h30, D2, '0, 1'b1);
    repeat (LAT + 2) step();
    issue(1'b0, 28'h30, '0, D2, 1'b1);
    step();
    bus.req_i = 1'b0;
    repeat (LAT + 1) step();

    // Early release plus input churn while BUSY.
    issue(1'b1, 28'h40, D3, '0, 1'b1);
    step();
    bus.req_i   = 1'b0;
    bus.addr_i  = 28'h41;
    bus.wdata_i = DJ;
    step();
    bus.req_i = 1'b1;
    repeat (LAT - 1) step();
    bus.req_i = 1'b0;
    step();
    run_op(1'b0, 28'h40, '0, D3);

    // Reset in BUSY drops an uncommitted write.
    run_op(1'b1, 28'h20, DA, '0);
    issue(1'b1, 28'h20, DB, '0, 1'b0);
    step();
    bus.req_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_rdy", 128'(bus.rdy_o), 128'(0));
    check("midrst_rdata", bus.rdata_o, 128'(0));
    check("midrst_wr_cnt", 128'(bus.wr_cnt_o), 128'(0));
    repeat (LAT + 2) step();
    run_op(1'b0, 28'h20, '0, DA);

    // Aliasing write, more writes, then read via the aliased index.
    run_op(1'b1, 28'h410, DC, '0);
    run_op(1'b1, 28'h50, D1, '0);
    run_op(1'b1, 28'h60, D2, '0);
    run_op(1'b0, 28'h10, '0, DC);

    repeat (3) step();
    check("queue_drained", 128'(q.size()), 128'(0));
`ifdef MEM_STATS_EN
    check("stats_wr_cnt", 128'(bus.wr_cnt_o), 128'(3));
    check("stats_rd_cnt", 128'(bus.rd_cnt_o), 128'(2));
`else
    check("stats_wr_cnt", 128'(bus.wr_cnt_o), 128'(0));
    check("stats_rd_cnt", 128'(bus.rd_cnt_o), 128'(0));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
